// File: rtl/sr_flag_arbiter_pkg.sv
// Shared constants for the SR flag arbiter: FSM state encoding and command opcodes.
package sr_flag_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_arbiter_bank.sv
// Bank of NFLAG SR status flops with synchronous active-low clear.
module sr_flag_bank
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NFLAG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NFLAG-1:0] s,
  input  logic [NFLAG-1:0] r,
  output logic [NFLAG-1:0] q
);

  logic [NFLAG-1:0] r_q;

  // SR update; the arbiter never raises s and r on the same flop together
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= (r_q | s) & ~r;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising set/clear commands from NREQ requesters onto an SR flag bank.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NFLAG-1:0]     flags
);

  localparam int              GW         = $clog2(NREQ);
  localparam logic [GW-1:0]   LAST_REQ   = GW'(NREQ - 1);
  localparam logic [IDXW:0]   FLAG_LIMIT = (IDXW + 1)'(NFLAG);

  logic [1:0]       r_state;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_g;
  logic             r_op;
  logic [IDXW-1:0]  r_idx;
  logic [NREQ-1:0]  r_ack;
  logic             r_err;
  logic             r_busy;

  logic             w_found;
  logic [GW-1:0]    w_win;
  logic [GW-1:0]    w_scan;
  logic             w_in_range;
  logic [NFLAG-1:0] w_s;
  logic [NFLAG-1:0] w_r;

  // Round-robin pick: first active requester scanning upward from r_ptr
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan  = GW'((int'(r_ptr) + i) % NREQ);
      w_win   = (!w_found && req[w_scan]) ? w_scan : w_win;
      w_found = w_found | req[w_scan];
    end
  end

  assign w_in_range = ({1'b0, r_idx} < FLAG_LIMIT);

  // One-hot s/r strobe, only during ISSUE and only for an in-range index
  always_comb begin
    w_s = '0;
    w_r = '0;
    if ((r_state == ST_ISSUE) && w_in_range) begin
      if (r_op == OP_SET) begin
        w_s[r_idx] = 1'b1;
      end else begin
        w_r[r_idx] = 1'b1;
      end
    end else begin
      w_s = '0;
      w_r = '0;
    end
  end

  // FSM, grant latch, pointer and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_op    <= OP_CLR;
      r_idx   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          r_err <= 1'b0;
          if (w_found) begin
            r_state <= ST_ISSUE;
            r_g     <= w_win;
            r_op    <= op[w_win];
            r_idx   <= idx[int'(w_win)*IDXW +: IDXW];
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_RELEASE;
          r_ack   <= NREQ'(1) << r_g;
          r_err   <= ~w_in_range;
          r_busy  <= 1'b1;
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_ptr   <= (r_g == LAST_REQ) ? GW'(0) : r_g + GW'(1);
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sr_flag_bank #(.NFLAG(NFLAG)) u_bank (
    .clk (clk),
    .rst (rst),
    .s   (w_s),
    .r   (w_r),
    .q   (flags)
  );

  assign ack  = r_ack;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic                 busy;
  logic [NFLAG-1:0]     flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .ack(ack), .err(err), .busy(busy), .flags(flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic o, input int ix);
    req[k] = 1'b1;
    op[k]  = o;
    idx[k*IDXW +: IDXW] = IDXW'(ix);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic test_reset();
    req = '1;
    op  = '1;
    idx = NREQ*IDXW'($urandom);
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
    end
    checks++;
    if (flags !== 6'h00) begin failures++; $display("FAIL reset_flags: got %h want 00", flags); end
    req = '0;
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_set();
    do_reset();
    set_cmd(1, 1'b1, 3);
    tick();
    checks++;
    if (busy !== 1'b1 || ack !== 4'b0000) begin
      failures++; $display("FAIL single_issue: busy=%b ack=%b want busy=1 ack=0000", busy, ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0010 || err !== 1'b0) begin
      failures++; $display("FAIL single_ack: ack=%b err=%b want ack=0010 err=0", ack, err);
    end
    checks++;
    if (flags !== 6'h08 || busy !== 1'b1) begin
      failures++; $display("FAIL single_flags: flags=%h busy=%b want flags=08 busy=1", flags, busy);
    end
    req[1] = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000) begin
      failures++; $display("FAIL single_done: busy=%b ack=%b want busy=0 ack=0000", busy, ack);
    end
  endtask

  task automatic test_round_robin();
    int exp_g;
    logic [NFLAG-1:0] exp_flags;
    req = '0;
    do_reset();
    for (int k = 0; k < NREQ; k++) set_cmd(k, 1'b1, k);
    exp_flags = '0;
    for (int n = 0; n < 5; n++) begin
      exp_g = n % NREQ;
      exp_flags[exp_g] = 1'b1;
      tick();
      tick();
      checks++;
      if (ack !== (4'b0001 << exp_g)) begin
        failures++; $display("FAIL rr_order grant %0d: ack=%b want %b", n, ack, 4'b0001 << exp_g);
      end
      checks++;
      if (flags !== exp_flags) begin
        failures++; $display("FAIL rr_flags grant %0d: got %h want %h", n, flags, exp_flags);
      end
      if (n == 4) req = '0;
      tick();
    end
    checks++;
    if (flags !== 6'h0F) begin failures++; $display("FAIL rr_final: got %h want 0f", flags); end
  endtask

  task automatic test_same_flag();
    req = '0;
    do_reset();
    set_cmd(0, 1'b1, 5);
    set_cmd(2, 1'b0, 5);
    tick();
    tick();
    checks++;
    if (ack !== 4'b0001 || flags[5] !== 1'b1) begin
      failures++; $display("FAIL conflict_first: ack=%b flag5=%b want ack=0001 flag5=1", ack, flags[5]);
    end
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ack !== 4'b0100 || flags[5] !== 1'b0) begin
      failures++; $display("FAIL conflict_second: ack=%b flag5=%b want ack=0100 flag5=0", ack, flags[5]);
    end
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    req = '0;
    do_reset();
    set_cmd(0, 1'b1, 1);
    tick();
    tick();
    req[0] = 1'b0;
    tick();
    set_cmd(3, 1'b1, 7);
    tick();
    tick();
    checks++;
    if (ack !== 4'b1000 || err !== 1'b1) begin
      failures++; $display("FAIL oor_ack_err: ack=%b err=%b want ack=1000 err=1", ack, err);
    end
    checks++;
    if (flags !== 6'h02) begin failures++; $display("FAIL oor_flags: got %h want 02", flags); end
    req[3] = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0 || flags !== 6'h02) begin
      failures++; $display("FAIL oor_after: err=%b flags=%h want err=0 flags=02", err, flags);
    end
  endtask

  task automatic test_reset_mid_issue();
    req = '0;
    do_reset();
    set_cmd(0, 1'b1, 0);
    tick();
    tick();
    req[0] = 1'b0;
    tick();
    set_cmd(2, 1'b1, 2);
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (flags !== 6'h00 || ack !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_state: flags=%h ack=%b busy=%b want 00/0000/0", flags, ack, busy);
    end
    rst = 1'b1;
    set_cmd(0, 1'b1, 4);
    tick();
    tick();
    checks++;
    if (ack !== 4'b0001 || flags !== 6'h10) begin
      failures++; $display("FAIL midreset_regrant: ack=%b flags=%h want ack=0001 flags=10", ack, flags);
    end
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ack !== 4'b0100 || flags !== 6'h14) begin
      failures++; $display("FAIL midreset_reissue: ack=%b flags=%h want ack=0100 flags=14", ack, flags);
    end
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0]      req_e, op_e, exp_ack;
    logic [NREQ*IDXW-1:0] idx_e;
    logic [NFLAG-1:0]     m_flags;
    logic                 exp_err, exp_busy, pend, pend_op;
    int next_free, m_ptr, arb_edge, pend_edge, pend_g, pend_idx, g;
    req = '0;
    do_reset();
    m_flags = '0; pend = 1'b0; pend_op = 1'b0;
    next_free = 0; m_ptr = 0; arb_edge = -10; pend_edge = -1; pend_g = 0; pend_idx = 0;
    for (int t = 0; t < 900; t++) begin
      req_e = req; op_e = op; idx_e = idx;
      tick();
      exp_ack = '0;
      exp_err = 1'b0;
      if (pend && t == pend_edge) begin
        exp_ack[pend_g] = 1'b1;
        exp_err = (pend_idx >= NFLAG);
        if (pend_idx < NFLAG) m_flags[pend_idx] = pend_op;
        pend = 1'b0;
      end
      g = -1;
      if (t >= next_free && req_e != '0) begin
        g = rr_pick(req_e, m_ptr);
        pend = 1'b1; pend_edge = t + 1; pend_g = g;
        pend_op = op_e[g]; pend_idx = int'(idx_e[g*IDXW +: IDXW]);
        next_free = t + 3; m_ptr = (g + 1) % NREQ; arb_edge = t;
      end
      exp_busy = (t == arb_edge) || (t == arb_edge + 1);
      checks++;
      if (ack !== exp_ack || err !== exp_err || busy !== exp_busy || flags !== m_flags) begin
        failures++;
        $display("FAIL random t=%0d: ack=%b err=%b busy=%b flags=%h want ack=%b err=%b busy=%b flags=%h",
                 t, ack, err, busy, flags, exp_ack, exp_err, exp_busy, m_flags);
      end
      if (g >= 0) begin
        op[g] = 1'($urandom_range(1, 0));
        idx[g*IDXW +: IDXW] = IDXW'($urandom_range(7, 0));
      end
      for (int k = 0; k < NREQ; k++) begin
        if (exp_ack[k]) begin
          if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
          else set_cmd(k, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
        end else if (!req[k] && $urandom_range(2, 0) == 0) begin
          set_cmd(k, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    op  = '0;
    idx = '0;
    test_reset();
    test_single_set();
    test_round_robin();
    test_same_flag();
    test_out_of_range();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
